// File: rtl/led_matrix_scan_ctrl.sv
// Row-scanning PWM controller for a multiplexed LED matrix with a double-buffered
// frame store; buffer swaps are deferred to the edge that ends the last row.
module led_matrix_scan_ctrl #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int PWM_BITS   = 3,
  parameter int SLOT_CLKS  = 16,
  parameter int BLANK_CLKS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [$clog2(COLS)-1:0]   wr_col,
  input  logic [PWM_BITS-1:0]       wr_data,
  input  logic                      swap_req,
  output logic                      swap_ack,
  output logic                      frame_start,
  output logic [ROWS-1:0]           row_sel,
  output logic [COLS-1:0]           col_drive
);

  localparam int RW      = $clog2(ROWS);
  localparam int CNT_MAX = (SLOT_CLKS > BLANK_CLKS) ? SLOT_CLKS : BLANK_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CLKS - 1);
  localparam logic [CNT_W-1:0]    SLOT_LAST  = CNT_W'(SLOT_CLKS - 1);
  localparam logic [PWM_BITS-1:0] SLOT_MAX   = '1;
  localparam logic [RW-1:0]       ROW_LAST   = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_run;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [PWM_BITS-1:0]   r_slot;
  logic [PWM_BITS-1:0]   w_slot_nxt;
  logic [RW-1:0]         r_row;
  logic [RW-1:0]         w_row_nxt;
  logic                  r_front;
  logic                  w_front_nxt;
  logic                  w_frame_nxt;
  logic                  w_ack_nxt;
  logic [ROWS-1:0]       w_row_sel_nxt;
  logic [COLS-1:0]       w_col_nxt;
  logic                  w_wr_ok;

  logic                  r_swap_ack;
  logic                  r_frame_start;
  logic [ROWS-1:0]       r_row_sel;
  logic [COLS-1:0]       r_col_drive;

  logic [PWM_BITS-1:0]   r_mem [2][ROWS][COLS];

  assign w_wr_ok = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);

  // Outputs are computed from the next state so the registered pins line up
  // with the state they describe, with no extra pipeline stage.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_slot_nxt    = r_slot;
    w_row_nxt     = r_row;
    w_front_nxt   = r_front;
    w_frame_nxt   = 1'b0;
    w_ack_nxt     = 1'b0;
    w_row_sel_nxt = '0;
    w_col_nxt     = '0;

    unique case (r_state)
      ST_INIT: begin
        if (r_run) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_frame_nxt = 1'b1;
        end
      end
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = '0;
          w_slot_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (r_cnt == SLOT_LAST) begin
          w_cnt_nxt = '0;
          if (r_slot == SLOT_MAX) begin
            w_state_nxt = ST_BLANK;
            if (r_row == ROW_LAST) begin
              // Frame boundary: the only point where the buffers may swap.
              w_row_nxt   = '0;
              w_frame_nxt = 1'b1;
              if (swap_req) begin
                w_front_nxt = ~r_front;
                w_ack_nxt   = 1'b1;
              end
            end else begin
              w_row_nxt = r_row + RW'(1);
            end
          end else begin
            w_slot_nxt = r_slot + PWM_BITS'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase

    if (w_state_nxt == ST_DRIVE) begin
      w_row_sel_nxt = ROWS'(1) << w_row_nxt;
      for (int c = 0; c < COLS; c++) begin
        w_col_nxt[c] = r_mem[w_front_nxt][w_row_nxt][c] > w_slot_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_INIT;
      r_run         <= 1'b0;
      r_cnt         <= '0;
      r_slot        <= '0;
      r_row         <= '0;
      r_front       <= 1'b0;
      r_swap_ack    <= 1'b0;
      r_frame_start <= 1'b0;
      r_row_sel     <= '0;
      r_col_drive   <= '0;
    end else begin
      r_run         <= 1'b1;
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_slot        <= w_slot_nxt;
      r_row         <= w_row_nxt;
      r_front       <= w_front_nxt;
      r_swap_ack    <= w_ack_nxt;
      r_frame_start <= w_frame_nxt;
      r_row_sel     <= w_row_sel_nxt;
      r_col_drive   <= w_col_nxt;
    end
  end

  // Writes target the pre-swap back buffer, so a write on the boundary edge
  // lands in the buffer that becomes the new front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            r_mem[b][r][c] <= '0;
          end
        end
      end
    end else if (w_wr_ok) begin
      r_mem[~r_front][wr_row][wr_col] <= wr_data;
    end
  end

  assign swap_ack    = r_swap_ack;
  assign frame_start = r_frame_start;
  assign row_sel     = r_row_sel;
  assign col_drive   = r_col_drive;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Scoreboard bench for led_matrix_scan_ctrl: an 8x8 instance checked every cycle
// against a frame-position model, plus a 6x6 instance fed only out-of-range writes.
module tb_led_matrix_scan_ctrl;

  localparam int BLANK   = 4;
  localparam int SLOT    = 16;
  localparam int ROWP    = BLANK + 8 * SLOT;
  localparam int FRAME   = 8 * ROWP;
  localparam int B_FRAME = 6 * ROWP;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, swap_req;
  logic [2:0] wr_row, wr_col, wr_data;
  logic       swap_ack, frame_start;
  logic [7:0] row_sel, col_drive;

  logic       b_wr_en, b_swap_req;
  logic [2:0] b_wr_row, b_wr_col, b_wr_data;
  logic       b_swap_ack, b_frame_start;
  logic [5:0] b_row_sel, b_col_drive;

  always #5 clk = ~clk;

  led_matrix_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_start(frame_start), .row_sel(row_sel), .col_drive(col_drive)
  );

  led_matrix_scan_ctrl #(.ROWS(6), .COLS(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_col(b_wr_col),
    .wr_data(b_wr_data), .swap_req(b_swap_req), .swap_ack(b_swap_ack),
    .frame_start(b_frame_start), .row_sel(b_row_sel), .col_drive(b_col_drive)
  );

  int         n_cmp = 0;
  int         n_mis = 0;
  int         cyc;
  logic [2:0] m_mem [2][8][8];
  logic       m_front;
  logic [17:0] exp_q[$];
  logic [6:0]  b_exp_q[$];
  int         win_lo, win_hi, win_first;
  int         win_cnt [8];

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [17:0] exp_out(input int n, input logic ack);
    logic [7:0] rs, cd;
    logic       fs;
    int         pos, row, w, slot;
    rs = '0;
    cd = '0;
    fs = 1'b0;
    if (n >= 1) begin
      pos = (n - 1) % FRAME;
      row = pos / ROWP;
      w   = pos % ROWP;
      fs  = (pos == 0);
      if (w >= BLANK) begin
        slot = (w - BLANK) / SLOT;
        rs   = 8'(1) << row;
        for (int c = 0; c < 8; c++) cd[c] = int'(m_mem[m_front][row][c]) > slot;
      end
    end
    return {fs, ack, rs, cd};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) m_mem[b][r][c] = '0;
    m_front = 1'b0;
    cyc     = -1;
    exp_q.delete();
    b_exp_q.delete();
  endtask

  task automatic set_win(input int lo, input int hi);
    win_lo    = lo;
    win_hi    = hi;
    win_first = 0;
    for (int c = 0; c < 8; c++) win_cnt[c] = 0;
  endtask

  task automatic step();
    int          n;
    logic        sw, bsw;
    logic [17:0] e;
    logic [6:0]  be;
    n   = cyc + 1;
    sw  = (n > 1) && ((n - 1) % FRAME == 0) && swap_req;
    bsw = (n > 1) && ((n - 1) % B_FRAME == 0) && b_swap_req;
    if (wr_en) m_mem[~m_front][wr_row][wr_col] = wr_data;
    if (sw) m_front = ~m_front;
    exp_q.push_back(exp_out(n, sw));
    b_exp_q.push_back({bsw, 6'b0});
    @(posedge clk);
    cyc = n;
    #1;
    e  = exp_q.pop_front();
    be = b_exp_q.pop_front();
    chk_val($sformatf("out@%0d", n), 32'({frame_start, swap_ack, row_sel, col_drive}), 32'(e));
    chk_val($sformatf("b_out@%0d", n), 32'({b_swap_ack, b_col_drive}), 32'(be));
    if (n >= win_lo && n <= win_hi) begin
      for (int c = 0; c < 8; c++) if (col_drive[c]) win_cnt[c]++;
      if (n < win_lo + 112 && col_drive[0]) win_first++;
    end
    wr_en   = 1'b0;
    b_wr_en = 1'b0;
    if (sw) swap_req = 1'b0;
    if (bsw) b_swap_req = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic write_px(input int r, input int c, input int v);
    wr_en   = 1'b1;
    wr_row  = 3'(r);
    wr_col  = 3'(c);
    wr_data = 3'(v);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; swap_req = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    b_wr_en = 1'b0; b_swap_req = 1'b0; b_wr_row = '0; b_wr_col = '0; b_wr_data = '0;
    set_win(-1, -1);
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_outs", 32'({frame_start, swap_ack, row_sel, col_drive}), 32'h0);
    chk_val("rst_b_outs", 32'({b_frame_start, b_swap_ack, b_row_sel, b_col_drive}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Power-up timing and 6x6 out-of-range writes.
    run_to(1);
    chk_val("fs_c1", 32'(frame_start), 32'h1);
    b_wr_en = 1'b1; b_wr_row = 3'd7; b_wr_col = 3'd2; b_wr_data = 3'd7;
    step();
    b_wr_en = 1'b1; b_wr_row = 3'd2; b_wr_col = 3'd7; b_wr_data = 3'd7;
    step();
    b_swap_req = 1'b1;
    run_to(4);   chk_val("rs_c4", 32'(row_sel), 32'h0);
    run_to(5);   chk_val("rs_c5", 32'(row_sel), 32'h1);
    run_to(99);
    swap_req = 1'b1;
    run_to(132); chk_val("rs_c132", 32'(row_sel), 32'h1);
    run_to(133); chk_val("rs_c133", 32'(row_sel), 32'h0);
    run_to(136); chk_val("rs_c136", 32'(row_sel), 32'h0);
    run_to(137); chk_val("rs_c137", 32'(row_sel), 32'h2);
    run_to(793); chk_val("b_ack_c793", 32'(b_swap_ack), 32'h1);
    run_to(1056); chk_val("ack_c1056", 32'(swap_ack), 32'h0);
    run_to(1057);
    chk_val("ack_c1057", 32'(swap_ack), 32'h1);
    chk_val("fs_c1057", 32'(frame_start), 32'h1);

    // PWM duty on row 0.
    write_px(0, 0, 7);
    write_px(0, 1, 3);
    write_px(0, 2, 0);
    swap_req = 1'b1;
    set_win(2 * FRAME + 1 + BLANK, 2 * FRAME + ROWP);
    run_to(2 * FRAME + ROWP);
    chk_val("duty_c0", 32'(win_cnt[0]), 32'd112);
    chk_val("duty_c0_run", 32'(win_first), 32'd112);
    chk_val("duty_c1", 32'(win_cnt[1]), 32'd48);
    chk_val("duty_c2", 32'(win_cnt[2]), 32'd0);

    // Back-buffer isolation, then swap it in.
    write_px(3, 3, 5);
    set_win(3 * FRAME + 1, 6 * FRAME);
    run_to(6300);
    swap_req = 1'b1;
    run_to(6 * FRAME);
    chk_val("iso_c3", 32'(win_cnt[3]), 32'd0);
    set_win(6 * FRAME + 1 + 3 * ROWP + BLANK, 6 * FRAME + 4 * ROWP);
    run_to(6 * FRAME + 4 * ROWP);
    chk_val("swap_r3_c3", 32'(win_cnt[3]), 32'd80);
    chk_val("swap_r3_c0", 32'(win_cnt[0]), 32'd0);

    // Light row 4, then reset in the middle of its drive period.
    write_px(4, 1, 7);
    swap_req = 1'b1;
    run_to(7 * FRAME + 1 + 4 * ROWP + BLANK + 5);
    chk_val("lit_rs_r4", 32'(row_sel), 32'h10);
    chk_val("lit_cd_r4", 32'(col_drive), 32'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("async_rs", 32'(row_sel), 32'h0);
    chk_val("async_cd", 32'(col_drive), 32'h0);
    chk_val("async_b", 32'({b_row_sel, b_col_drive}), 32'h0);
    model_reset();
    set_win(-1, -1);
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst2_outs", 32'({frame_start, swap_ack, row_sel, col_drive}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_to(0);   chk_val("re_fs_c0", 32'(frame_start), 32'h0);
    run_to(1);   chk_val("re_fs_c1", 32'(frame_start), 32'h1);
    run_to(5);   chk_val("re_rs_c5", 32'(row_sel), 32'h1);
    run_to(FRAME + 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan_ctrl.md
# led_matrix_scan_ctrl

Row-scanning controller for the multiplexed LED matrix. It holds a double-buffered frame of per-pixel brightness values and drives one row at a time with PWM column data. Blanking intervals separate rows, and front/back buffer swaps occur only at frame boundaries. It sits between the pattern-generating logic (write/swap side) and the matrix row/column drivers in `top`. At the default 12 MHz clock it refreshes at about 11.4 kHz.

## Interface

- `ROWS`, 8, number of matrix rows (≥2)
- `COLS`, 8, number of matrix columns (≥2)
- `PWM_BITS`, 3, brightness bits per pixel; 2^PWM_BITS PWM slots per row
- `SLOT_CLKS`, 16, clocks per PWM slot (≥1)
- `BLANK_CLKS`, 4, clocks of blanking before each row (≥1)

Ports:

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write one pixel into the back buffer this cycle
- `wr_row`  in  $clog2(ROWS)  pixel row
- `wr_col`  in  $clog2(COLS)  pixel column
- `wr_data`  in  PWM_BITS  brightness (0 = off)
- `swap_req`  in  1  level request to exchange front/back buffers; held until `swap_ack`
- `swap_ack`  out  1  one-cycle pulse when the swap has taken effect
- `frame_start`  out  1  one-cycle pulse on the first cycle of each frame
- `row_sel`  out  ROWS  one-hot active-high row enable; all-zero during blanking
- `col_drive`  out  COLS  active-high column drive for the selected row

## Operation

- Storage: two ROWS×COLS×PWM_BITS buffers. `front_sel` picks the displayed buffer; the other buffer is the back buffer.
- Writes: when `wr_en` is high, `wr_data` goes to back[`wr_row`][`wr_col`].
  - Writes with `wr_row`≥ROWS or `wr_col`≥COLS are ignored.
  - Writes are accepted every cycle; there is no backpressure.
- FSM states:
  - INIT: one cycle after reset release, then → BLANK.
  - BLANK: lasts BLANK_CLKS cycles, then → DRIVE.
  - DRIVE: lasts 2^PWM_BITS × SLOT_CLKS cycles, then → BLANK of the next row.
  - Row counter `r` advances at DRIVE exit and wraps ROWS-1 → 0.
- Outputs:
  - BLANK/INIT: `row_sel`=0, `col_drive`=0.
  - DRIVE in slot p (0..2^PWM_BITS-1): `row_sel`=1<<r, `col_drive`[c] = (front[r][c] > p).
  - Value v is therefore lit for v slots. Value 0 is never lit; the maximum value is lit for all but one slot.
- Frame boundary: the clock edge leaving DRIVE of row ROWS-1.
  - If `swap_req` is high on that cycle, `front_sel` toggles on that edge.
  - `swap_ack` pulses in the following cycle, coinciding with `frame_start`.
  - `swap_req` sampled high at any other time stays pending until the next boundary.
- Simultaneous write and swap on the boundary edge: the write lands in the pre-swap back buffer, which becomes the new front.
- After a swap, the new back buffer holds the old front contents. It is not cleared.

## Timing

- All outputs are registered and consistent with the FSM state in the same cycle. There is no extra pipeline stage between state and pins.
- Reset (`rst_n` low, asynchronous; takes effect immediately, including mid-DRIVE):
  - All outputs are 0.
  - Both buffers are cleared to 0.
  - `front_sel`=0, `r`=0, state=INIT.
- Cycle numbering: cycle 0 is the first rising edge with `rst_n` high. That edge is the INIT cycle.
- Cycle 1 is the first BLANK of row 0, with `frame_start`=1.
- Default row period: 4 + 8×16 = 132 clocks. Default frame: 1056 clocks.
- Frame k starts at cycle 1 + 1056k.
- Write-to-display latency: the next frame boundary with `swap_req` high. The minimum is 1 cycle before the boundary.

## Test plan

- Reset:
  - Stimulus: hold `rst_n` low, then release.
  - Required response: all outputs 0 during reset and at cycle 0.
  - `frame_start`=1 only at cycle 1.
  - `row_sel`=0 for cycles 1–4, 0x01 for cycles 5–132, 0 for cycles 133–136, 0x02 from cycle 137.
  - `frame_start` pulses again at cycle 1057.
- PWM duty:
  - Stimulus: write (0,0)=7, (0,1)=3, (0,2)=0, then hold `swap_req`.
  - Required response in row 0 of the frame after `swap_ack`:
    - col0 high for 112 consecutive clocks, then low for 16.
    - col1 high for 48 clocks.
    - col2 never high.
- Swap handshake:
  - Stimulus: raise `swap_req` at cycle 100 and hold it.
  - Required response: `swap_ack`=1 only at cycle 1057, with `frame_start`.
  - With `swap_req` low, no `swap_ack` occurs and the display is unchanged.
- Back-buffer isolation:
  - Stimulus: write (3,3)=5 with no swap.
  - Required response: row 3 columns stay 0 for 3 full frames.
  - After swap, col3 is lit for 80 clocks during row 3.
- Out-of-range write:
  - Stimulus: ROWS=COLS=6, write (7,2)=7 and (2,7)=7, then swap.
  - Required response: all `col_drive` bits stay 0 every frame.
- Mid-operation reset:
  - Stimulus: assert `rst_n` low during row 4 DRIVE with the display lit.
  - Required response: `row_sel`/`col_drive` are 0 immediately, without waiting for a clock.
  - After release, the sequence restarts at INIT.
  - The display stays dark until new writes and a swap.
